// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states,
// and the immediate-format and writeback-source selects seen by the datapath.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    TRAP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_U    = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath
// plus shared memory port (slave).
interface multicycle_ctrl_if;

  logic [31:0] instr_i;
  logic        mem_ack_i;
  logic        zero_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        addr_sel_o;
  logic        ir_write_o;
  logic [2:0]  imm_sel_o;
  logic        alu_src_b_o;
  logic [1:0]  wb_sel_o;
  logic        reg_write_o;
  logic        pc_write_o;
  logic        pc_src_o;
  logic        retire_o;
  logic        illegal_o;

  modport master (
    input  instr_i, mem_ack_i, zero_i,
    output mem_req_o, mem_we_o, addr_sel_o, ir_write_o, imm_sel_o, alu_src_b_o,
           wb_sel_o, reg_write_o, pc_write_o, pc_src_o, retire_o, illegal_o
  );

  modport slave (
    output instr_i, mem_ack_i, zero_i,
    input  mem_req_o, mem_we_o, addr_sel_o, ir_write_o, imm_sel_o, alu_src_b_o,
           wb_sel_o, reg_write_o, pc_write_o, pc_src_o, retire_o, illegal_o
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 classifier feeding the multi-cycle sequencer.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output imm_sel_t   imm_sel,
  output logic       alu_src_b,
  output wb_sel_t    wb_sel,
  output logic       is_mem,
  output logic       is_branch,
  output logic       legal
);

  always_comb begin
    imm_sel   = IMM_NONE;
    alu_src_b = 1'b0;
    wb_sel    = WB_ALU;
    is_mem    = 1'b0;
    is_branch = 1'b0;
    legal     = 1'b1;
    unique case (opcode)
      OP_R:   ;
      OP_IMM: begin imm_sel = IMM_I; alu_src_b = 1'b1; end
      OP_LUI: begin imm_sel = IMM_U; alu_src_b = 1'b1; end
      OP_LOAD: begin
        imm_sel = IMM_I; alu_src_b = 1'b1; is_mem = 1'b1; wb_sel = WB_MEM;
      end
      OP_STORE: begin imm_sel = IMM_S; alu_src_b = 1'b1; is_mem = 1'b1; end
      OP_BRANCH: begin
        // Only BEQ/BNE are implemented; other compares must look fully illegal.
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          imm_sel   = IMM_B;
          is_branch = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_JAL:  begin imm_sel = IMM_J; wb_sel = WB_PC4; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with a req/ack memory port.
// Optional: define MEM_TIMEOUT_EN to trap when memory fails to ack within TIMEOUT_CYCLES.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  ctrl_state_t state, state_next;
  logic [6:0]  opcode_q, opcode;
  logic [2:0]  funct3_q, funct3;
  imm_sel_t    dec_imm_sel;
  wb_sel_t     dec_wb_sel;
  logic        dec_alu_src_b, dec_is_mem, dec_is_branch, dec_legal;
  logic        timeout;
  logic        unused_instr_bits;

  // DECODE sees the live IR; later states use the copy captured on leaving DECODE.
  assign opcode = (state == DECODE) ? bus.instr_i[6:0]   : opcode_q;
  assign funct3 = (state == DECODE) ? bus.instr_i[14:12] : funct3_q;
  assign unused_instr_bits = ^{bus.instr_i[31:15], bus.instr_i[11:7]};

  ctrl_decode u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .imm_sel   (dec_imm_sel),
    .alu_src_b (dec_alu_src_b),
    .wb_sel    (dec_wb_sel),
    .is_mem    (dec_is_mem),
    .is_branch (dec_is_branch),
    .legal     (dec_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      opcode_q <= '0;
      funct3_q <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        opcode_q <= bus.instr_i[6:0];
        funct3_q <= bus.instr_i[14:12];
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == FETCH || state == MEM) && !bus.mem_ack_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires during the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout = !bus.mem_ack_i && (wait_cnt == CNT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // NOTE: every output and the next state get a default first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.addr_sel_o  = 1'b0;
    bus.ir_write_o  = 1'b0;
    bus.imm_sel_o   = IMM_NONE;
    bus.alu_src_b_o = 1'b0;
    bus.wb_sel_o    = WB_ALU;
    bus.reg_write_o = 1'b0;
    bus.pc_write_o  = 1'b0;
    bus.pc_src_o    = 1'b0;
    bus.retire_o    = 1'b0;
    bus.illegal_o   = 1'b0;
    unique case (state)
      FETCH: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_ack_i) begin
          bus.ir_write_o = 1'b1;
          state_next     = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        bus.imm_sel_o = dec_imm_sel;
        state_next    = dec_legal ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        bus.imm_sel_o   = dec_imm_sel;
        bus.alu_src_b_o = dec_alu_src_b;
        if (dec_is_branch) begin
          bus.pc_write_o = 1'b1;
          bus.pc_src_o   = bus.zero_i ^ (funct3 == F3_BNE);
          bus.retire_o   = 1'b1;
          state_next     = FETCH;
        end else begin
          state_next = dec_is_mem ? MEM : WRITEBACK;
        end
      end
      MEM: begin
        bus.imm_sel_o  = dec_imm_sel;
        bus.mem_req_o  = 1'b1;
        bus.addr_sel_o = 1'b1;
        bus.mem_we_o   = (opcode == OP_STORE);
        if (bus.mem_ack_i) begin
          if (opcode == OP_STORE) begin
            bus.pc_write_o = 1'b1;
            bus.retire_o   = 1'b1;
            state_next     = FETCH;
          end else begin
            state_next = WRITEBACK;
          end
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      WRITEBACK: begin
        bus.imm_sel_o   = dec_imm_sel;
        bus.wb_sel_o    = dec_wb_sel;
        bus.reg_write_o = 1'b1;
        bus.pc_write_o  = 1'b1;
        bus.pc_src_o    = (opcode == OP_JAL);
        bus.retire_o    = 1'b1;
        state_next      = FETCH;
      end
      TRAP:    bus.illegal_o = 1'b1;
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle timeline built from the
// instruction-level rules, compared against the DUT every cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       addr_sel;
    logic       ir_write;
    logic [2:0] imm;
    logic       alu_b;
    logic [1:0] wb;
    logic       reg_w;
    logic       pc_w;
    logic       pc_src;
    logic       retire;
    logic       illegal;
  } outv_t;

  typedef struct packed {
    logic  ack;
    outv_t exp;
  } cyc_t;

  localparam int TO_CYC = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] JUNK = 32'h0000_007F;

  logic      clk;
  logic      reset;
  int        checks = 0;
  int        errors = 0;
  int        cyc_no = 0;
  logic      exp_valid = 1'b0;
  outv_t     exp_cur;
  outv_t     got;
  string     cur_name = "idle";
  cyc_t      sched[$];

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single compare process: checks the DUT against the current expectation each cycle.
  always @(negedge clk) begin
    #2;
    cyc_no++;
    if (exp_valid) begin
      got = {bus_if.mem_req_o, bus_if.mem_we_o, bus_if.addr_sel_o, bus_if.ir_write_o,
             bus_if.imm_sel_o, bus_if.alu_src_b_o, bus_if.wb_sel_o, bus_if.reg_write_o,
             bus_if.pc_write_o, bus_if.pc_src_o, bus_if.retire_o, bus_if.illegal_o};
      checks++;
      if (got !== exp_cur) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", cur_name, cyc_no, got, exp_cur);
      end
    end
  end

  function automatic void push(input logic a, input outv_t o);
    cyc_t c;
    c.ack = a;
    c.exp = o;
    sched.push_back(c);
  endfunction

  function automatic void push_trap(input logic noise);
    outv_t o;
    for (int i = 0; i < 3; i++) begin
      o = '0;
      o.illegal = 1'b1;
      push(noise, o);
    end
  endfunction

  // Instruction-level model: the cycle timeline one instruction must produce.
  function automatic void build(input logic [31:0] instr, input int fw, input int mw,
                                input logic zero, input logic noise);
    logic [6:0] op;
    logic [2:0] f3, fmt;
    logic [1:0] wb;
    logic       legal, ld, st, br, jal, alu_b;
    outv_t      o;
    op = instr[6:0];
    f3 = instr[14:12];
    legal = 1'b1; ld = 1'b0; st = 1'b0; br = 1'b0; jal = 1'b0; alu_b = 1'b0;
    fmt = 3'd0; wb = 2'd0;
    case (op)
      7'h33: ;
      7'h13: begin fmt = 3'd1; alu_b = 1'b1; end
      7'h37: begin fmt = 3'd2; alu_b = 1'b1; end
      7'h03: begin fmt = 3'd1; alu_b = 1'b1; ld = 1'b1; wb = 2'd1; end
      7'h23: begin fmt = 3'd3; alu_b = 1'b1; st = 1'b1; end
      7'h63: begin fmt = 3'd4; br = 1'b1; legal = (f3 == 3'd0) || (f3 == 3'd1); end
      7'h6F: begin fmt = 3'd5; jal = 1'b1; wb = 2'd2; end
      default: legal = 1'b0;
    endcase
    if (!legal) fmt = 3'd0;
    sched.delete();
    for (int i = 0; i < fw; i++) begin
      if (TO_EN && i == TO_CYC) begin push_trap(noise); return; end
      o = '0; o.req = 1'b1; push(1'b0, o);
    end
    o = '0; o.req = 1'b1; o.ir_write = 1'b1; push(1'b1, o);
    o = '0; o.imm = fmt; push(noise, o);
    if (!legal) begin push_trap(noise); return; end
    o = '0; o.imm = fmt; o.alu_b = alu_b;
    if (br) begin
      o.pc_w = 1'b1; o.retire = 1'b1; o.pc_src = (f3 == 3'd0) ? zero : !zero;
      push(noise, o);
      return;
    end
    push(noise, o);
    if (ld || st) begin
      for (int i = 0; i < mw; i++) begin
        if (TO_EN && i == TO_CYC) begin push_trap(noise); return; end
        o = '0; o.imm = fmt; o.req = 1'b1; o.addr_sel = 1'b1; o.we = st; push(1'b0, o);
      end
      o = '0; o.imm = fmt; o.req = 1'b1; o.addr_sel = 1'b1; o.we = st;
      o.pc_w = st; o.retire = st;
      push(1'b1, o);
      if (st) return;
    end
    o = '0; o.imm = fmt; o.reg_w = 1'b1; o.pc_w = 1'b1; o.retire = 1'b1;
    o.wb = wb; o.pc_src = jal;
    push(noise, o);
  endfunction

  // Plays one instruction (optionally truncated) and checks the hand-computed retire cycle.
  task automatic run(input string name, input logic [31:0] instr, input int fw, input int mw,
                     input logic zero, input logic noise, input int max_cyc, input int exp_lat);
    int n;
    int ret_cyc;
    ret_cyc = 0;
    build(instr, fw, mw, zero, noise);
    n = sched.size();
    if (max_cyc > 0 && max_cyc < n) n = max_cyc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus_if.instr_i   = (sched[c].exp.req && !sched[c].exp.addr_sel) ? JUNK : instr;
      bus_if.zero_i    = zero;
      bus_if.mem_ack_i = sched[c].ack;
      exp_cur   = sched[c].exp;
      exp_valid = 1'b1;
      cur_name  = name;
      #3;
      if (bus_if.retire_o === 1'b1 && ret_cyc == 0) ret_cyc = c + 1;
    end
    if (exp_lat > 0) begin
      checks++;
      if (ret_cyc != exp_lat) begin
        errors++;
        $display("FAIL %s_latency: retired in cycle %0d, required cycle %0d", name, ret_cyc, exp_lat);
      end
    end
  endtask

  task automatic do_reset(input string name);
    outv_t rst_vec;
    rst_vec = '0;
    rst_vec.req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus_if.mem_ack_i = 1'b0;
    exp_cur = rst_vec; exp_valid = 1'b1; cur_name = name;
    @(negedge clk);
    reset = 1'b0;
    exp_cur = rst_vec; cur_name = {name, "_release"};
  endtask

  initial begin
    reset = 1'b1;
    bus_if.instr_i   = '0;
    bus_if.mem_ack_i = 1'b0;
    bus_if.zero_i    = 1'b0;
    do_reset("reset");

    run("addi",       32'h0050_0093, 0, 0, 1'b0, 1'b0, 0, 4);
    run("lw_wait2",   32'h0000_A103, 2, 2, 1'b0, 1'b0, 0, 9);
    run("beq_taken",  32'h0020_8463, 0, 0, 1'b1, 1'b0, 0, 3);
    run("bne_zero",   32'h0020_9463, 0, 0, 1'b1, 1'b0, 0, 3);
    run("beq_nz",     32'h0020_8463, 0, 0, 1'b0, 1'b1, 0, 3);
    run("bne_taken",  32'h0020_9463, 1, 0, 1'b0, 1'b1, 0, 4);
    run("sw",         32'h0020_A023, 0, 0, 1'b0, 1'b0, 0, 4);
    run("sw_wait1",   32'h0020_A023, 0, 1, 1'b0, 1'b1, 0, 5);
    run("jal",        32'h0080_00EF, 0, 0, 1'b0, 1'b1, 0, 4);
    run("lui",        32'h0000_10B7, 0, 0, 1'b0, 1'b0, 0, 4);
    run("add",        32'h0020_81B3, 0, 0, 1'b1, 1'b1, 0, 4);
    run("lw",         32'h0000_A103, 0, 0, 1'b0, 1'b1, 0, 5);

    run("bad_branch", 32'h0020_A463, 0, 0, 1'b0, 1'b1, 0, 0);
    do_reset("reset_trap_branch");
    run("opcode_7f",  32'h0000_007F, 0, 0, 1'b0, 1'b1, 0, 0);
    do_reset("reset_trap_7f");

    run("lw_cut",     32'h0000_A103, 1, 3, 1'b0, 1'b0, 6, 0);
    do_reset("reset_mid_lw");
    run("addi_after", 32'h0050_0093, 0, 0, 1'b0, 1'b0, 0, 4);

`ifdef MEM_TIMEOUT_EN
    run("fetch_timeout", 32'h0050_0093, 100, 0, 1'b0, 1'b0, 0, 0);
    do_reset("reset_fetch_timeout");
    run("mem_timeout",   32'h0000_A103, 0, 100, 1'b0, 1'b0, 0, 0);
    do_reset("reset_mem_timeout");
`else
    run("addi_wait7",    32'h0050_0093, 7, 0, 1'b0, 1'b0, 0, 11);
`endif
    run("addi_final",    32'h0050_0093, 0, 0, 1'b0, 1'b0, 0, 4);

    @(negedge clk);
    exp_valid = 1'b0;
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RISC-V core datapath. Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the write enables, mux selects and immediate-format select consumed by the immediate unit, ALU, register file and PC. Memory access uses a req/ack handshake, so the datapath can share one memory port for fetch and data.

## Interface
- `TIMEOUT_CYCLES`, 255 — maximum cycles `mem_req_o` may wait for `mem_ack_i`; used only with `MEM_TIMEOUT_EN`.
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-high reset.
- `instr_i` in 32 — instruction register contents; valid from DECODE onward.
- `mem_ack_i` in 1 — memory completes the current request this cycle.
- `zero_i` in 1 — ALU zero flag; sampled in EXECUTE.
- `mem_req_o` out 1 — memory request; held until ack.
- `mem_we_o` out 1 — request is a store.
- `addr_sel_o` out 1 — memory address source: 0 = PC, 1 = ALU result.
- `ir_write_o` out 1 — load `instr_i` source into IR (pulse).
- `imm_sel_o` out 3 — immediate format: 0 none, 1 I, 2 U, 3 S, 4 B, 5 J.
- `alu_src_b_o` out 1 — ALU operand B: 0 = rs2, 1 = immediate.
- `wb_sel_o` out 2 — writeback source: 0 ALU, 1 memory data, 2 PC+4.
- `reg_write_o` out 1 — register file write (pulse).
- `pc_write_o` out 1 — PC update (pulse).
- `pc_src_o` out 1 — next PC: 0 = PC+4, 1 = PC+imm.
- `retire_o` out 1 — one-cycle pulse per completed instruction.
- `illegal_o` out 1 — sticky; set on an unsupported opcode or timeout.

## Operation
- Decoded opcodes:
  - `0x33` R
  - `0x13` I-ALU
  - `0x37` LUI
  - `0x03` LOAD
  - `0x23` STORE
  - `0x63` BRANCH (funct3 000 BEQ, 001 BNE)
  - `0x6F` JAL
- Any other opcode, or any other BRANCH funct3, → TRAP.
- FETCH:
  - Drives `mem_req_o`=1, `mem_we_o`=0, `addr_sel_o`=0.
  - On `mem_ack_i`: pulses `ir_write_o`, goes to DECODE.
- DECODE (1 cycle):
  - Registers opcode/funct3 from `instr_i`.
  - Drives `imm_sel_o` by format: R→0, I-ALU/LOAD→1, LUI→2, STORE→3, BRANCH→4, JAL→5.
  - `imm_sel_o` holds that value through the last state of the instruction.
- EXECUTE (1 cycle):
  - `alu_src_b_o`=1 for I-ALU, LUI, LOAD and STORE; 0 otherwise.
  - BRANCH: `pc_write_o`=1, `pc_src_o`=(BEQ ? `zero_i` : !`zero_i`), `retire_o`=1, then FETCH.
  - LOAD/STORE → MEM. All other opcodes → WRITEBACK.
- MEM:
  - `mem_req_o`=1, `addr_sel_o`=1, `mem_we_o`=1 for STORE.
  - On ack: LOAD → WRITEBACK; STORE pulses `pc_write_o` (`pc_src_o`=0) and `retire_o`, then FETCH.
- WRITEBACK (1 cycle):
  - Pulses `reg_write_o`, `pc_write_o` and `retire_o`.
  - `wb_sel_o`: 0 for R/I-ALU/LUI, 1 for LOAD, 2 for JAL.
  - `pc_src_o`=1 for JAL, else 0. Then FETCH.
- TRAP: absorbing. All strobes 0, `illegal_o`=1, no memory requests; only `reset` exits.
- All pulse outputs are combinational from the state register and are never high in two consecutive cycles for one instruction.

## Timing
- Reset: state=FETCH; all outputs 0 except `mem_req_o`=1 (combinational from FETCH); `illegal_o`=0.
- Latency with zero-wait memory (ack in the request cycle):
  - BRANCH: 3 cycles.
  - R/I/LUI/JAL/STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `mem_req_o`, `mem_we_o` and `addr_sel_o` are stable while waiting.
- `mem_ack_i` outside FETCH/MEM is ignored.
- `reset` asserted mid-instruction: immediate return to FETCH; no partial writes; `illegal_o` cleared.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter (`$clog2(TIMEOUT_CYCLES+1)` bits) clears on state entry and increments each un-acked cycle in FETCH/MEM.
  - When it reaches `TIMEOUT_CYCLES` without ack → TRAP, `illegal_o`=1.
- `MEM_TIMEOUT_EN` undefined: no counter; waits indefinitely.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - Opcode localparams.
  - Enum `ctrl_state_t` (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP).
  - `imm_sel_t` and `wb_sel_t` encodings, shared with the immediate unit and writeback mux.
- One sub-module, `ctrl_decode`: combinational opcode/funct3 → {`imm_sel`, `alu_src_b`, `wb_sel`, `is_mem`, `is_branch`, `legal`}. The FSM lives in `multicycle_ctrl`.

## Test plan
- ADDI `0x00500093`, ack in the request cycle:
  - `imm_sel_o`=1, `alu_src_b_o`=1.
  - `reg_write_o` and `retire_o` in cycle 4; `wb_sel_o`=0.
- LW `0x0000A103` with ack delayed 2 cycles in both FETCH and MEM:
  - `mem_req_o` held each wait; `wb_sel_o`=1.
  - Retire at cycle 9.
- BEQ `0x00208463`:
  - `zero_i`=1 → `pc_write_o`=1, `pc_src_o`=1 in cycle 3.
  - Repeat with BNE: `pc_src_o`=0.
- SW `0x0020A023`:
  - `mem_we_o`=1, `addr_sel_o`=1 in MEM.
  - No `reg_write_o`; retire in cycle 4.
- Opcode `0x7F`: TRAP, `illegal_o`=1, `mem_req_o`=0. Assert `reset` → FETCH, `illegal_o`=0.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4, ack never asserted: `illegal_o` rises after 4 FETCH wait cycles.
